vga_capture: RTL
================

Name: vga_capture

Overview:
- Receive end of the VGA link. Watches hsync/vsync and the 3-bit RGB lanes on the pixel clock.
- Recovers the (x, y) coordinate of every active pixel and thresholds it to a 1-bit edge/no-edge value.
- Emits a write stream (coordinate, bit, valid, frame markers) that loads the edge bitmap store used for loopback checking of the display path.

Parameters:
- WIDTH, 640, active pixels per line
- DEPTH, 480, active lines per frame
- HPULSE, 96, hsync low width in dclk cycles
- HBP, 48, cycles from hsync rising edge to first active pixel
- VPULSE, 2, vsync low width in lines
- VBP, 33, lines from vsync rising edge to first active line
- THRESH, 11, red+green+blue value at or above which a pixel is 1

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr  in  1  synchronous reset, active-low (0 = reset, sampled on rising dclk)
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- red  in  3  red lane
- green  in  3  green lane
- blue  in  3  blue lane
- pix_valid  out  1  pix_x/pix_y/pix_bit valid this cycle
- pix_x  out  10  active column 0..WIDTH-1
- pix_y  out  10  active row 0..DEPTH-1
- pix_bit  out  1  1 when red+green+blue >= THRESH
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- frame_done  out  1  one-cycle pulse with pixel (WIDTH-1,DEPTH-1)
- locked  out  1  high while inside a frame that began with a clean vsync
- sync_err  out  1  sticky error flag; see Optional Feature

Behaviour:
- Reset (clr=0 at a dclk edge):
  - all outputs 0; state SEEK; counters 0; input registers loaded with hsync=1, vsync=1, rgb=0.
  - Reset mid-frame discards the frame; no frame_done is issued.
- Input stage: hsync, vsync and rgb are registered once. Edges are detected on the registered copies against a second delayed copy.
- hcnt (11 bits):
  - cleared to 0 on the cycle the registered hsync shows a falling edge; otherwise increments.
  - Saturates at 2047, so a missing hsync never wraps into a false active region.
- vcnt (10 bits):
  - cleared to 0 on a registered vsync falling edge; otherwise increments on each hsync falling edge.
  - Saturates at 1023.
- Active region: hcnt in [HPULSE+HBP, HPULSE+HBP+WIDTH-1] and vcnt in [VPULSE+VBP, VPULSE+VBP+DEPTH-1]. There, pix_x = hcnt-(HPULSE+HBP) and pix_y = vcnt-(VPULSE+VBP).
- Thresholding: sum = red+green+blue, computed zero-extended to 5 bits (no overflow, max 21); pix_bit = (sum >= THRESH).
- Latency: RGB sampled at edge k appears on pix_* after edge k+2 (input register plus output register). All outputs are registered.
- State machine:
  - SEEK: locked=0, pix_valid never asserted. A vsync falling edge moves to FRAME.
  - FRAME: locked=1; pix_valid asserted in the active region. After the cycle that emits (WIDTH-1, DEPTH-1) with frame_done, move to WAIT.
  - WAIT: locked=1, no output. A vsync falling edge moves to FRAME (back-to-back frames need no SEEK).
- Boundary conditions:
  - vsync falling edge while in FRAME before frame_done: early frame. Restart FRAME with vcnt=0, no frame_done, sync_err event.
  - hsync falling edge before WIDTH pixels of a line: line truncated, next line starts normally, sync_err event.
  - vsync and hsync falling edges in the same cycle: vcnt=0 and hcnt=0; the hsync edge does not increment vcnt.
  - Sync edges present before the first vsync: ignored in SEEK.
  - frame_start and pix_valid coincide at (0,0); frame_done and pix_valid coincide at (WIDTH-1, DEPTH-1).

Optional Feature:
- Macro: VGA_CAPTURE_SYNC_CHECK_EN.
- Defined: sync_err is set by any sync_err event above. It is also set when hsync low width differs from HPULSE or vsync low width differs from VPULSE lines. It stays set until reset.
- Not defined: sync_err is tied to 0 and the width checkers are not built. Early-frame and truncated-line recovery behave identically.

Test Plan:
- Reset held 5 cycles mid-stream -> all outputs 0, state SEEK; after release no pix_valid until the next vsync fall.
- One clean 640x480 frame, every pixel rgb=111/111/111 -> exactly 307200 pix_valid, all pix_bit=1; frame_start with (0,0); frame_done with (639,479); locked=1.
- Pixels with rgb 011/011/100 (sum 10) then 011/100/100 (sum 11) -> pix_bit 0 then 1. Output appears 2 cycles after the input sample.
- vsync fall after line 200 of the active region -> no frame_done; next pix_valid is (0,0) with frame_start. With macro defined sync_err=1; without it sync_err=0.
- hsync fall after 300 active pixels of row 10 -> row 10 emits x=0..299 only; row 11 emits full x=0..639.
- With macro defined, hsync pulse of 95 cycles -> sync_err rises within 2 cycles of the hsync rising edge and remains 1 until clr=0.

Source files
------------

// File: rtl/vga_capture.sv
// VGA receive end: recovers (x, y) of each active pixel from hsync/vsync and thresholds RGB to one bit.
// Define VGA_CAPTURE_SYNC_CHECK_EN to build the sticky sync_err flag and the sync pulse width checkers.
module vga_capture #(
  parameter int WIDTH  = 640,
  parameter int DEPTH  = 480,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VPULSE = 2,
  parameter int VBP    = 33,
  parameter int THRESH = 11
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [2:0] blue,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_bit,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [10:0] HSTART = 11'(HPULSE + HBP);
  localparam logic [10:0] HLAST  = 11'(HPULSE + HBP + WIDTH - 1);
  localparam logic [9:0]  VSTART = 10'(VPULSE + VBP);
  localparam logic [9:0]  VLAST  = 10'(VPULSE + VBP + DEPTH - 1);
  localparam logic [9:0]  XLAST  = 10'(WIDTH - 1);
  localparam logic [9:0]  YLAST  = 10'(DEPTH - 1);
  localparam logic [4:0]  THR    = 5'(THRESH);

  typedef enum logic [1:0] {ST_SEEK, ST_FRAME, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q, hs_d1_q, vs_d1_q;
  logic [8:0]  rgb_q, rgb_d1_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        pix_bit_q, pix_bit_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        locked_q, locked_d;

  logic        hs_fall, vs_fall, in_h, in_v, active, last_px;
  logic [9:0]  x, y;
  logic [4:0]  sum;

  // rgb_d1_q lines up with hcnt_q/vcnt_q, which lag the input register by one edge
  always_comb begin
    hs_fall = hs_d1_q & ~hs_q;
    vs_fall = vs_d1_q & ~vs_q;
    hcnt_d  = hs_fall ? 11'd0 : ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1);
    vcnt_d  = vcnt_q;
    if (vs_fall)
      vcnt_d = 10'd0;
    else if (hs_fall && vcnt_q != 10'h3FF)
      vcnt_d = vcnt_q + 10'd1;
    in_h    = (hcnt_q >= HSTART) && (hcnt_q <= HLAST);
    in_v    = (vcnt_q >= VSTART) && (vcnt_q <= VLAST);
    active  = (state_q == ST_FRAME) && in_h && in_v;
    x       = hcnt_q[9:0] - HSTART[9:0];
    y       = vcnt_q - VSTART;
    sum     = 5'(rgb_d1_q[8:6]) + 5'(rgb_d1_q[5:3]) + 5'(rgb_d1_q[2:0]);
    last_px = active && (x == XLAST) && (y == YLAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK:  if (vs_fall) state_d = ST_FRAME;
      ST_FRAME: begin
        if (vs_fall)
          state_d = ST_FRAME;
        else if (last_px)
          state_d = ST_WAIT;
      end
      ST_WAIT:  if (vs_fall) state_d = ST_FRAME;
      default:  state_d = ST_SEEK;
    endcase
  end

  always_comb begin
    pix_valid_d   = active;
    pix_x_d       = active ? x : 10'd0;
    pix_y_d       = active ? y : 10'd0;
    pix_bit_d     = active && (sum >= THR);
    frame_start_d = active && (x == 10'd0) && (y == 10'd0);
    frame_done_d  = last_px;
    locked_d      = (state_q != ST_SEEK);
  end

  always_ff @(posedge dclk) begin
    if (!clr) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hs_d1_q       <= 1'b1;
      vs_d1_q       <= 1'b1;
      rgb_q         <= 9'd0;
      rgb_d1_q      <= 9'd0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 10'd0;
      state_q       <= ST_SEEK;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_bit_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      hs_q          <= hsync;
      vs_q          <= vsync;
      hs_d1_q       <= hs_q;
      vs_d1_q       <= vs_q;
      rgb_q         <= {red, green, blue};
      rgb_d1_q      <= rgb_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      state_q       <= state_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_bit_q     <= pix_bit_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      locked_q      <= locked_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_bit     = pix_bit_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
  logic [10:0] hlow_q, hlow_d;
  logic [9:0]  vlow_q, vlow_d;
  logic        sync_err_q, sync_err_d;
  logic        hs_rise, vs_rise, early, trunc, hbad, vbad;

  // vsync width is counted in lines: the falling line counts as the first
  always_comb begin
    hs_rise = hs_q & ~hs_d1_q;
    vs_rise = vs_q & ~vs_d1_q;
    hlow_d  = hs_q ? 11'd0 : ((hlow_q == 11'h7FF) ? hlow_q : hlow_q + 11'd1);
    vlow_d  = vlow_q;
    if (vs_fall)
      vlow_d = 10'd1;
    else if (!vs_q && hs_fall && vlow_q != 10'h3FF)
      vlow_d = vlow_q + 10'd1;
    early      = vs_fall && (state_q == ST_FRAME);
    trunc      = hs_fall && (state_q == ST_FRAME) && in_v && (hcnt_q < HLAST);
    hbad       = hs_rise && (state_q != ST_SEEK) && (hlow_q != 11'(HPULSE));
    vbad       = vs_rise && (state_q != ST_SEEK) && (vlow_q != 10'(VPULSE));
    sync_err_d = sync_err_q | early | trunc | hbad | vbad;
  end

  always_ff @(posedge dclk) begin
    if (!clr) begin
      hlow_q     <= 11'd0;
      vlow_q     <= 10'd0;
      sync_err_q <= 1'b0;
    end else begin
      hlow_q     <= hlow_d;
      vlow_q     <= vlow_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule
